skinny_sbox_masked_pipe: RTL and testbench
==========================================

# skinny_sbox_masked_pipe

- Parametrised, first-order (2-share) masked Skinny-64 S-box layer.
- Applies `NUM_SBOX` independent low-latency GHPC-style ANF S-box gadgets in parallel.
- Runs behind a two-stage valid/ready pipeline with full backpressure.
- Sits between the masked state register and the ShiftRows/MixColumns layer of a round-based masked Skinny core; replaces per-S-box instantiation plus hand-placed output registers.

## Interface
Parameters:
- `NUM_SBOX`, default 16: number of 4-bit S-boxes processed per transfer (1..16).
- `FRESH_PER_SBOX`, default 64: fresh random bits consumed per S-box per transfer.

Ports:
- `clk` input 1: single clock; all registers on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `X_s0`/`X_s1`/`Fresh` hold a transfer.
- `in_ready` output 1: pipeline accepts this cycle.
- `X_s0`, `X_s1` input 4*NUM_SBOX: input shares; nibble i is S-box i, bit 0 of nibble = bit X[0].
- `Fresh` input FRESH_PER_SBOX*NUM_SBOX (+4*NUM_SBOX with refresh): randomness; slice i feeds S-box i.
- `out_valid` output 1: `Y_s0`/`Y_s1` hold a result.
- `out_ready` input 1: consumer accepts this cycle.
- `Y_s0`, `Y_s1` output 4*NUM_SBOX: output shares; `Y_s0 ^ Y_s1` = S(X_s0 ^ X_s1) per nibble.
- `busy` output 1: any pipeline stage holds valid data.

## Operation
- `adv = !(out_valid && !out_ready)`; `in_ready = adv`. Asserting `in_ready` does not depend on `in_valid`.
- Stage 1 is the gadget's internal register layer; stage 2 is the output share register. Each stage has a valid bit `v1`, `v2`.
- When `adv`=1, in one cycle:
  - gadget stage-1 registers load;
  - `v1 <= in_valid`;
  - output registers load the gadget outputs;
  - `v2 <= v1`.
- When `adv`=0, every data and valid register holds, including the gadget-internal registers (clock-enable, never clock gating). Partial products must not be recomputed with changed `Fresh`.
- Transfer accepted iff `in_valid && in_ready`. `Fresh` is sampled in that same cycle, and each accepted transfer uses a new `Fresh` value.
- `Fresh` is don't-care in any cycle without acceptance.
- Bubbles (`in_valid`=0 while `adv`=1) propagate as `v`=0. Data registers still load but are ignored.
- `out_valid = v2`; `busy = v1 | v2`.
- Shares are never combined or unmasked in this block. No register, mux select or control signal depends on unshared data.
- Nibble bit ordering feeds each gadget as {X[0],X[1],X[2],X[3]}.
- Output nibble permutation per S-box: Y[3]←out[1], Y[2]←out[3], Y[1]←out[0], Y[0]←out[2] of the gadget output bus.

## Timing
- Latency: 2 cycles from acceptance to `out_valid` with no stall; 1 transfer/cycle throughput.
- Reset (async assert, synchronous release on `clk`):
  - `v1`=`v2`=0;
  - `Y_s0`=`Y_s1`=0;
  - `out_valid`=0, `busy`=0, `in_ready`=1.
  - Gadget-internal data registers are not reset; they are qualified by `v1`.
- Reset mid-operation discards all in-flight transfers. The first transfer accepted after release appears 2 cycles later.
- Full pipeline with `out_ready`=0 holds 2 transfers; `in_ready`=0 until `out_ready` rises.
- `out_ready` and `in_valid` both high with the pipe full: output is consumed and input is accepted in the same cycle.

## Configuration
- `SBOX_OUT_REFRESH_EN` defined:
  - `Fresh` widens by 4*NUM_SBOX bits (top bits), captured with the transfer and delayed to stage 2.
  - Mask m is XORed into both output shares at the output register load.
  - Latency and unshared value are unchanged.
- Undefined: no refresh, `Fresh` width is FRESH_PER_SBOX*NUM_SBOX.

## Test plan
- Reset, NUM_SBOX=1: X=0x0 split as s0=0x5, s1=0x5; `out_ready`=1 → `out_valid` exactly 2 cycles later; `Y_s0^Y_s1`=0xC; `busy`=1 for 2 cycles.
- Exhaustive, NUM_SBOX=16: stream all 16 values in back-to-back cycles with random shares/Fresh. Expect unshared outputs 0xC,6,9,0,1,A,2,B,3,8,5,D,4,E,7,F in order, one per cycle.
- Backpressure: `out_ready`=0 after 3 accepts. Expect `in_ready` to fall once 2 transfers are in flight, third held at input. Toggle `Fresh` and shares during the stall: outputs are unchanged and the results stay correct after release.
- Bubbles: `in_valid` pattern 1,0,1,1 → `out_valid` pattern 1,0,1,1 delayed by 2 cycles.
- Reset mid-flight: assert `rst` with 2 in flight → `out_valid`=0 and Y shares=0 immediately; no stale output after release.
- `SBOX_OUT_REFRESH_EN`: same share input twice with different refresh masks → `Y_s0` differs, `Y_s0^Y_s1` identical.

Source files
------------

// File: rtl/skinny_sbox_masked_pipe.sv
`default_nettype none
// ============================================================================
// Module      : skinny_sbox_masked_pipe
// Description : First-order (2-share) masked Skinny-64 S-box layer.
//               NUM_SBOX low-latency ANF gadgets run in parallel behind a
//               two-stage valid/ready pipeline with full backpressure.
//
//               Stage 1 is the gadget register layer. It holds the
//               cross-domain ANF terms, each refreshed with one fresh bit,
//               plus the per-output XOR of those fresh bits.
//               Stage 2 is the output share register.
//
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               in_valid/in_ready - input handshake (in_ready = advance)
//               X_s0, X_s1        - input shares, nibble i feeds S-box i
//               Fresh             - randomness, FRESH_PER_SBOX bits per S-box
//                                   (+4 mask bits per S-box in the top bits
//                                   when SBOX_OUT_REFRESH_EN is defined)
//               out_valid/out_ready - output handshake
//               Y_s0, Y_s1        - output shares, Y_s0^Y_s1 = S(X_s0^X_s1)
//               busy              - any stage holds valid data
//
// Config      : `define SBOX_OUT_REFRESH_EN to XOR a fresh 4-bit mask per
//               S-box into both output shares at the output register.
//
// Revision    : 1.0 - initial release
// ============================================================================
module skinny_sbox_masked_pipe #(
    parameter int NUM_SBOX       = 16,
    parameter int FRESH_PER_SBOX = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [4*NUM_SBOX-1:0]                  X_s0,
    input  logic [4*NUM_SBOX-1:0]                  X_s1,
`ifdef SBOX_OUT_REFRESH_EN
    input  logic [(FRESH_PER_SBOX+4)*NUM_SBOX-1:0] Fresh,
`else
    input  logic [FRESH_PER_SBOX*NUM_SBOX-1:0]     Fresh,
`endif
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [4*NUM_SBOX-1:0]                  Y_s0,
    output logic [4*NUM_SBOX-1:0]                  Y_s1,
    output logic                                   busy
);

    // 4 output bits x 16 share-domain choice vectors = 64 refreshed terms
    localparam int c_NUM_TERMS = 64;

    function automatic logic [3:0] skinny_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h6;  4'h2: y = 4'h9;  4'h3: y = 4'h0;
            4'h4: y = 4'h1;  4'h5: y = 4'hA;  4'h6: y = 4'h2;  4'h7: y = 4'hB;
            4'h8: y = 4'h3;  4'h9: y = 4'h8;  4'hA: y = 4'h5;  4'hB: y = 4'hD;
            4'hC: y = 4'h4;  4'hD: y = 4'hE;  4'hE: y = 4'h7;  default: y = 4'hF;
        endcase
        return y;
    endfunction

    // ANF coefficients of the gadget function in its own bus orders:
    // input bus {X[0],X[1],X[2],X[3]}, output bus bit j such that
    // Y = {out[1], out[3], out[0], out[2]}. Bit j*16+m is the coefficient
    // of monomial m (bit i of m = input-bus bit i) in output bit j.
    function automatic logic [63:0] gadget_anf();
        logic [63:0] tt;
        logic [3:0]  x;
        logic [3:0]  y;
        tt = '0;
        for (int g = 0; g < 16; g++) begin
            x = {g[0], g[1], g[2], g[3]};
            y = skinny_sbox(x);
            tt[0*16+g] = y[1];
            tt[1*16+g] = y[3];
            tt[2*16+g] = y[0];
            tt[3*16+g] = y[2];
        end
        // In-place Moebius transform, truth table -> ANF
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                for (int g = 0; g < 16; g++)
                    if (g[i])
                        tt[j*16+g] = tt[j*16+g] ^ tt[j*16+(g ^ (1 << i))];
        return tt;
    endfunction

    localparam logic [63:0] c_ANF = gadget_anf();

    // ------------------------------------------------------------------
    // Pipeline control: share-independent, driven only by handshakes
    // ------------------------------------------------------------------
    logic                  w_adv;
    logic                  r_v1;
    logic                  r_v2;
    logic [4*NUM_SBOX-1:0] r_y_s0;
    logic [4*NUM_SBOX-1:0] r_y_s1;
    logic [4*NUM_SBOX-1:0] w_y_s0_d;
    logic [4*NUM_SBOX-1:0] w_y_s1_d;

    assign w_adv     = ~(r_v2 & ~out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r_v2;
    assign busy      = r_v1 | r_v2;
    assign Y_s0      = r_y_s0;
    assign Y_s1      = r_y_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_y_s0 <= '0;
            r_y_s1 <= '0;
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_v2   <= r_v1;
            r_y_s0 <= w_y_s0_d;
            r_y_s1 <= w_y_s1_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-S-box gadgets
    // ------------------------------------------------------------------
    for (genvar s = 0; s < NUM_SBOX; s++) begin : g_sbox
        logic [3:0]             w_a;
        logic [3:0]             w_b;
        logic [c_NUM_TERMS-1:0] w_fresh;
        logic [c_NUM_TERMS-1:0] w_term;
        logic [3:0]             w_rsum;
        logic [c_NUM_TERMS-1:0] r_term;
        logic [3:0]             r_rsum;
        logic [3:0]             w_o0;
        logic [3:0]             w_m;

        assign w_a = {X_s0[4*s+0], X_s0[4*s+1], X_s0[4*s+2], X_s0[4*s+3]};
        assign w_b = {X_s1[4*s+0], X_s1[4*s+1], X_s1[4*s+2], X_s1[4*s+3]};

        // A narrower FRESH_PER_SBOX wraps around and reuses bits
        for (genvar k = 0; k < c_NUM_TERMS; k++) begin : g_fresh
            assign w_fresh[k] = Fresh[s*FRESH_PER_SBOX + (k % FRESH_PER_SBOX)];
        end

        // Term (j,d): every expanded monomial of output bit j whose share
        // choice is d, with variables outside the monomial pinned to
        // share 0 so each expansion product lands in exactly one term.
        // Each term mixes at most one share per input bit and is
        // refreshed before it reaches a register.
        always_comb begin
            logic p;
            logic t;
            p      = 1'b0;
            t      = 1'b0;
            w_term = '0;
            for (int j = 0; j < 4; j++) begin
                for (int d = 0; d < 16; d++) begin
                    t = 1'b0;
                    for (int m = 0; m < 16; m++) begin
                        if (c_ANF[j*16+m] && ((d & ~m) == 0)) begin
                            p = 1'b1;
                            for (int i = 0; i < 4; i++)
                                if (m[i])
                                    p = p & (d[i] ? w_b[i] : w_a[i]);
                            t = t ^ p;
                        end
                    end
                    w_term[j*16+d] = t ^ w_fresh[j*16+d];
                end
            end
        end

        // The second share carries the XOR of the randomness used above
        for (genvar j = 0; j < 4; j++) begin : g_rsum
            assign w_rsum[j] = ^w_fresh[j*16 +: 16];
            assign w_o0[j]   = ^r_term[j*16 +: 16];
        end

        // Gadget-internal layer: clock-enabled, not reset, qualified by v1
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_term <= w_term;
                r_rsum <= w_rsum;
            end
        end

`ifdef SBOX_OUT_REFRESH_EN
        logic [3:0] r_mask;
        always_ff @(posedge clk) begin
            if (w_adv)
                r_mask <= Fresh[FRESH_PER_SBOX*NUM_SBOX + 4*s +: 4];
        end
        assign w_m = r_mask;
`else
        assign w_m = 4'h0;
`endif

        assign w_y_s0_d[4*s +: 4] = {w_o0[1], w_o0[3], w_o0[0], w_o0[2]} ^ w_m;
        assign w_y_s1_d[4*s +: 4] = {r_rsum[1], r_rsum[3], r_rsum[0], r_rsum[2]} ^ w_m;
    end

endmodule
`default_nettype wire

// File: tb/tb_skinny_sbox_masked_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_skinny_sbox_masked_pipe
// Description : Self-checking bench for skinny_sbox_masked_pipe (16 S-boxes).
//               Expected results come from a table-lookup S-box reference
//               applied to the unshared input captured at acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skinny_sbox_masked_pipe;

    localparam int NS = 16;
    localparam int FP = 64;
`ifdef SBOX_OUT_REFRESH_EN
    localparam int FW = (FP + 4) * NS;
`else
    localparam int FW = FP * NS;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [63:0]   X_s0      = '0;
    logic [63:0]   X_s1      = '0;
    logic [63:0]   Y_s0;
    logic [63:0]   Y_s1;
    logic [FW-1:0] Fresh     = '0;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    always #5 clk = ~clk;

    skinny_sbox_masked_pipe #(
        .NUM_SBOX       (NS),
        .FRESH_PER_SBOX (FP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_s0      (X_s0),
        .X_s1      (X_s1),
        .Fresh     (Fresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y_s0      (Y_s0),
        .Y_s1      (Y_s1),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] sbox_ref(input logic [3:0] x);
        logic [3:0] tbl [16];
        tbl = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};
        return tbl[x];
    endfunction

    function automatic logic [63:0] layer_ref(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox_ref(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic rand_fresh();
        for (int i = 0; i < FW; i++) Fresh[i] = 1'($urandom());
    endtask

    task automatic set_x(input logic [63:0] x);
        X_s0 = rand64();
        X_s1 = X_s0 ^ x;
    endtask

    // Called at posedge+1; records acceptances and consumed outputs, then
    // advances to the next posedge+1.
    task automatic tick();
        #1;
        if (in_valid && in_ready) exp_q.push_back(layer_ref(X_s0 ^ X_s1));
        if (out_valid && out_ready) obs_q.push_back(Y_s0 ^ Y_s1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (Y_s0 !== 64'h0) begin failures++; $display("FAIL rst_y_s0: got %h expected 0", Y_s0); end
        checks++; if (Y_s1 !== 64'h0) begin failures++; $display("FAIL rst_y_s1: got %h expected 0", Y_s1); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_latency();
        logic [63:0] x;
        logic [63:0] y;
        x = rand64(); x[3:0] = 4'h0;
        X_s0 = rand64(); X_s0[3:0] = 4'h5;
        X_s1 = X_s0 ^ x;
        out_ready = 1'b1; in_valid = 1'b1; rand_fresh();
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_c1_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_c1_busy: got %b expected 1", busy); end
        tick();
        y = Y_s0 ^ Y_s1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_c2_valid: got %b expected 1", out_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_c2_busy: got %b expected 1", busy); end
        checks++; if (y[3:0] !== 4'hC) begin failures++; $display("FAIL lat_nibble0: got %h expected c", y[3:0]); end
        checks++; if (y !== layer_ref(x)) begin failures++; $display("FAIL lat_layer: got %h expected %h", y, layer_ref(x)); end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL lat_c3_idle: got valid=%b busy=%b expected 0/0", out_valid, busy); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_exhaustive();
        logic [63:0] x;
        logic [63:0] y;
        logic [3:0]  nib [16];
        nib = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) begin
                for (int i = 0; i < 16; i++) x[4*i +: 4] = 4'((k + i) % 16);
                set_x(x); rand_fresh(); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            checks++; if (out_valid !== (k >= 2)) begin failures++; $display("FAIL exh_valid_%0d: got %b expected %b", k, out_valid, (k >= 2)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL exh_end_valid: got %b expected 0", out_valid); end
        checks++; if (obs_q.size() != 16) begin failures++; $display("FAIL exh_count: got %0d expected 16", obs_q.size()); end
        for (int k = 0; k < 16 && k < obs_q.size(); k++) begin
            y = obs_q[k];
            checks++; if (y[3:0] !== nib[k]) begin failures++; $display("FAIL exh_nib_%0d: got %h expected %h", k, y[3:0], nib[k]); end
            checks++; if (y !== exp_q[k]) begin failures++; $display("FAIL exh_layer_%0d: got %h expected %h", k, y, exp_q[k]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [63:0] xs [3];
        logic [63:0] h0;
        logic [63:0] h1;
        for (int i = 0; i < 3; i++) xs[i] = rand64();
        out_ready = 1'b0; in_valid = 1'b1;
        set_x(xs[0]); rand_fresh();
        tick();
        set_x(xs[1]); rand_fresh();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one: got %b expected 1", in_ready); end
        tick();
        set_x(xs[2]); rand_fresh();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL bp_full_flags: got valid=%b busy=%b expected 1/1", out_valid, busy); end
        h0 = Y_s0; h1 = Y_s1;
        for (int c = 0; c < 4; c++) begin
            set_x(xs[2]); rand_fresh();
            tick();
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready_%0d: got %b expected 0", c, in_ready); end
            checks++; if (Y_s0 !== h0 || Y_s1 !== h1) begin failures++; $display("FAIL bp_stall_hold_%0d: got %h/%h expected %h/%h", c, Y_s0, Y_s1, h0, h1); end
            checks++; if (exp_q.size() != 2) begin failures++; $display("FAIL bp_stall_accepts_%0d: got %0d expected 2", c, exp_q.size()); end
        end
        checks++; if ((h0 ^ h1) !== layer_ref(xs[0])) begin failures++; $display("FAIL bp_held_value: got %h expected %h", h0 ^ h1, layer_ref(xs[0])); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL bp_count: got %0d expected 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== layer_ref(xs[i])) begin failures++; $display("FAIL bp_result_%0d: got %h expected %h", i, obs_q[i], layer_ref(xs[i])); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bubbles();
        logic [7:0] pat;
        logic       expv;
        pat = 8'b0000_1101;
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            set_x(rand64()); rand_fresh();
            in_valid = pat[t];
            expv = (t >= 2) ? pat[t-2] : 1'b0;
            checks++; if (out_valid !== expv) begin failures++; $display("FAIL bub_valid_%0d: got %b expected %b", t, out_valid, expv); end
            tick();
        end
        checks++; if (obs_q.size() != 3 || exp_q.size() != 3) begin failures++; $display("FAIL bub_count: got %0d/%0d expected 3/3", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bub_result_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic [63:0] x;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_x(rand64()); rand_fresh();
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_flags: got valid=%b busy=%b expected 0/0", out_valid, busy); end
        checks++; if (Y_s0 !== 64'h0 || Y_s1 !== 64'h0) begin failures++; $display("FAIL mid_rst_y: got %h/%h expected 0/0", Y_s0, Y_s1); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_%0d: got %b expected 0", c, out_valid); end
            tick();
        end
        x = rand64();
        set_x(x); rand_fresh(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_after_valid: got %b expected 1", out_valid); end
        checks++; if ((Y_s0 ^ Y_s1) !== layer_ref(x)) begin failures++; $display("FAIL mid_after_value: got %h expected %h", Y_s0 ^ Y_s1, layer_ref(x)); end
        tick();
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 300; c++) begin
            set_x(rand64()); rand_fresh();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                checks++; failures++;
                $display("FAIL rand_result_%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end else begin
                checks++;
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef SBOX_OUT_REFRESH_EN
    task automatic test_refresh();
        logic [63:0]   x;
        logic [63:0]   s0;
        logic [63:0]   m1;
        logic [63:0]   m2;
        logic [63:0]   ya0;
        logic [63:0]   ya1;
        logic [63:0]   yb0;
        logic [63:0]   yb1;
        logic [FW-1:0] f;
        x = rand64(); s0 = rand64();
        m1 = rand64(); m2 = m1 ^ (rand64() | 64'h1);
        rand_fresh(); f = Fresh;
        out_ready = 1'b1; in_valid = 1'b1;
        X_s0 = s0; X_s1 = s0 ^ x;
        Fresh = f; Fresh[FW-1 -: 64] = m1;
        tick();
        Fresh = f; Fresh[FW-1 -: 64] = m2;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ref_valid_a: got %b expected 1", out_valid); end
        ya0 = Y_s0; ya1 = Y_s1;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ref_valid_b: got %b expected 1", out_valid); end
        yb0 = Y_s0; yb1 = Y_s1;
        checks++; if (ya0 === yb0) begin failures++; $display("FAIL ref_s0_differs: got %h twice expected different", ya0); end
        checks++; if ((ya0 ^ yb0) !== (m1 ^ m2)) begin failures++; $display("FAIL ref_s0_delta: got %h expected %h", ya0 ^ yb0, m1 ^ m2); end
        checks++; if ((ya0 ^ ya1) !== layer_ref(x)) begin failures++; $display("FAIL ref_value_a: got %h expected %h", ya0 ^ ya1, layer_ref(x)); end
        checks++; if ((yb0 ^ yb1) !== layer_ref(x)) begin failures++; $display("FAIL ref_value_b: got %h expected %h", yb0 ^ yb1, layer_ref(x)); end
        tick();
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_exhaustive();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        test_random_stream();
`ifdef SBOX_OUT_REFRESH_EN
        test_refresh();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
